pc_fetch_sequencer: RTL

//  Control FSM for the PC mux. Drives pc_src (00 reset vector, 01 EPC, 10 trap vector, 11 next_pc).

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/pc_seq_perf_cnt.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC fetch sequencer: PC mux selects, FSM states, pending redirects.
package pc_seq_pkg;

  localparam logic [1:0] PC_SRC_RST  = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_e;
  typedef enum logic [1:0] {NONE, TRAP, MRET} pend_e;

endpackage

// File: rtl/pc_seq_perf_cnt.sv
// Free-running wrap-around counters for retired PC advances and stall/wait cycles.
module pc_seq_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_instret_in,
  input  logic             inc_stall_in,
  output logic [CNT_W-1:0] instret_cnt_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_stall;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_instret <= '0;
      r_stall   <= '0;
    end else begin
      if (inc_instret_in) r_instret <= r_instret + CNT_W'(1);
      if (inc_stall_in)   r_stall   <= r_stall + CNT_W'(1);
    end
  end

  assign instret_cnt_out = r_instret;
  assign stall_cnt_out   = r_stall;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC mux control FSM and architectural PC register, paced by AHB HREADY.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      pc_mux_in,
  input  logic             ahb_ready_in,
  input  logic             stall_in,
  input  logic             trap_req_in,
  input  logic             mret_in,
  input  logic             misaligned_instr_in,
  output logic [1:0]       pc_src_out,
  output logic [31:0]      pc_out,
  output logic             pc_we_out,
  output logic             fetch_valid_out,
  output logic             flush_out,
  output logic             cause_misalign_out,
  output logic [CNT_W-1:0] instret_cnt_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_e        r_state;
  pend_e         r_pend;
  logic [BW-1:0] r_boot_cnt;
  logic [31:0]   r_pc;
  logic          r_fetch_valid;
  logic          r_cause_mis;

  logic       w_trap, w_evt, w_boot_done, w_redir, w_redir_trap, w_capture;
  logic [1:0] w_pc_src;
  logic       w_we, w_flush;

  assign w_trap       = trap_req_in | misaligned_instr_in;
  assign w_evt        = w_trap | mret_in;
  assign w_boot_done  = (r_boot_cnt == BW'(BOOT_CYCLES - 1));
  // A redirect fires on any ready cycle outside BOOT, including the WAIT cycle
  // where the held fetch finally completes, so a queued event costs no extra cycle.
  assign w_redir      = (r_state != BOOT) && ahb_ready_in && ((r_pend != NONE) || w_evt);
  assign w_redir_trap = w_trap || (r_pend == TRAP);
  assign w_capture    = (r_state != BOOT) && !ahb_ready_in && w_evt;

  always_comb begin
    w_pc_src = PC_SRC_NEXT;
    w_we     = 1'b0;
    w_flush  = 1'b0;
    case (r_state)
      BOOT: begin
        w_pc_src = PC_SRC_RST;
        w_we     = w_boot_done;
      end
      RUN, WAIT: begin
        if (w_redir) begin
          w_pc_src = w_redir_trap ? PC_SRC_TRAP : PC_SRC_EPC;
          w_we     = 1'b1;
          w_flush  = 1'b1;
        end else if (r_state == RUN && ahb_ready_in && !stall_in) begin
          w_we = 1'b1;
        end
      end
      default: w_pc_src = PC_SRC_RST;
    endcase
    if (!rst_in) begin
      w_we    = 1'b0;
      w_flush = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state       <= BOOT;
      r_pend        <= NONE;
      r_boot_cnt    <= '0;
      r_pc          <= '0;
      r_fetch_valid <= 1'b0;
      r_cause_mis   <= 1'b0;
    end else begin
      if (w_we) r_pc <= pc_mux_in;
      case (r_state)
        BOOT: begin
          if (w_boot_done) begin
            r_state       <= RUN;
            r_fetch_valid <= 1'b1;
          end else begin
            r_boot_cnt <= r_boot_cnt + BW'(1);
          end
        end
        RUN:     if (!ahb_ready_in) r_state <= WAIT;
        WAIT:    if (ahb_ready_in)  r_state <= RUN;
        default: r_state <= BOOT;
      endcase
      // Trap outranks MRET: a new trap replaces anything, MRET only fills an empty slot.
      if (w_redir)
        r_pend <= NONE;
      else if (w_capture && w_trap)
        r_pend <= TRAP;
      else if (w_capture && r_pend != TRAP)
        r_pend <= MRET;
      if (r_state != BOOT && w_trap) r_cause_mis <= misaligned_instr_in;
    end
  end

  assign pc_src_out         = w_pc_src;
  assign pc_out             = r_pc;
  assign pc_we_out          = w_we;
  assign flush_out          = w_flush;
  assign fetch_valid_out    = r_fetch_valid;
  assign cause_misalign_out = r_cause_mis;

`ifdef PC_SEQ_PERF_EN
  logic w_inc_instret, w_inc_stall;
  assign w_inc_instret = w_we && (r_state == RUN) && !w_redir;
  assign w_inc_stall   = (r_state == WAIT) || ((r_state == RUN) && stall_in);

  pc_seq_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .inc_instret_in  (w_inc_instret),
    .inc_stall_in    (w_inc_stall),
    .instret_cnt_out (instret_cnt_out),
    .stall_cnt_out   (stall_cnt_out)
  );
`else
  assign instret_cnt_out = '0;
  assign stall_cnt_out   = '0;
`endif

endmodule
